// File: rtl/lampfpu_fma_round.sv
// FMA result rounder: 2-entry input FIFO (EMPTY/ONE/TWO), mode-selectable rounding, registered output.
// Latency 1 cycle from valid_i to valid_o when empty. ready_o is high only when empty; an input arriving while full without a pop is dropped (drop_o).
// Optional accumulated flags register enabled by FMA_ROUND_FFLAGS_EN.
module lampfpu_fma_round #(
    parameter int F_EXP  = 8,
    parameter int F_MANT = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    sign_i,
    input  logic [F_EXP-1:0]        exp_i,
    input  logic [F_MANT+4:0]       mant_i,
    input  logic                    ovf_i,
    input  logic                    unf_i,
    input  logic                    to_round_i,
    input  logic                    invalid_i,
    input  logic [2:0]              rnd_mode_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [F_EXP+F_MANT:0]   res_o,
    output logic [4:0]              flags_o,
    output logic                    drop_o,
    output logic [4:0]              fflags_o,
    input  logic                    fflags_clr_i
);
    localparam int RW = 1 + F_EXP + F_MANT;
    localparam logic [F_EXP:0] EXP_ONES = {1'b0, {F_EXP{1'b1}}};
    localparam logic [F_EXP:0] EXP_MAXF = EXP_ONES - 1'b1;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    typedef struct packed {
        logic               sign;
        logic [F_EXP-1:0]   exp;
        logic [F_MANT+4:0]  mant;
        logic               ovf;
        logic               unf;
        logic               to_round;
        logic               invalid;
        logic [2:0]         rnd_mode;
    } entry_t;

    state_t state, state_nxt;
    entry_t in_ent, spare, src;
    logic   pop, push, load;

    assign in_ent = {sign_i, exp_i, mant_i, ovf_i, unf_i, to_round_i, invalid_i, rnd_mode_i};

    // The output register holds the rounded head entry; only the second entry is stored raw.
    assign pop  = valid_o & ready_i;
    assign push = valid_i & ((state != TWO) | pop);
    assign load = ((state == EMPTY) & push) | pop;
    assign src  = (state == TWO) ? spare : in_ent;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (push) state_nxt = ONE;
            ONE:     if (push & ~pop) state_nxt = TWO;
                     else if (~push & pop) state_nxt = EMPTY;
            TWO:     if (pop & ~push) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        ready_o = (state == EMPTY);
        drop_o  = valid_i & (state == TWO) & ~pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spare <= '0;
        end else if (push & (((state == ONE) & ~pop) | ((state == TWO) & pop))) begin
            spare <= in_ent;
        end
    end

    logic                carry, g, r, st, inexact, up, to_inf, ovf_det;
    logic [F_MANT+2:0]   mn;
    logic [F_MANT-1:0]   frac;
    logic [F_MANT:0]     sum;
    logic [F_EXP:0]      en, er;
    logic [RW-1:0]       rnd_res;
    logic [4:0]          rnd_flags;

    always_comb begin
        carry   = src.mant[F_MANT+4];
        mn      = carry ? {src.mant[F_MANT+3:2], |src.mant[1:0]} : src.mant[F_MANT+2:0];
        en      = {1'b0, src.exp} + {{F_EXP{1'b0}}, carry};
        frac    = mn[F_MANT+2:3];
        g       = mn[2];
        r       = mn[1];
        st      = mn[0];
        inexact = g | r | st;
        case (src.rnd_mode)
            3'b001:  up = 1'b0;
            3'b010:  up = inexact & src.sign;
            3'b011:  up = inexact & ~src.sign;
            3'b100:  up = g;
            default: up = g & (r | st | frac[0]);
        endcase
        case (src.rnd_mode)
            3'b001:  to_inf = 1'b0;
            3'b010:  to_inf = src.sign;
            3'b011:  to_inf = ~src.sign;
            default: to_inf = 1'b1;
        endcase
        sum = {1'b0, frac} + {{F_MANT{1'b0}}, up};
        er  = en + {{F_EXP{1'b0}}, sum[F_MANT]};
        // Overflow also when the exact magnitude already exceeds max finite, whatever the mode.
        ovf_det = src.ovf | (er >= EXP_ONES) | ((en == EXP_MAXF) & (&frac) & inexact);

        rnd_flags = {src.invalid, 4'b0000};
        if (!src.to_round) begin
            rnd_res = {src.sign, src.exp, src.mant[F_MANT+2:3]};
        end else if (src.unf) begin
            rnd_res        = {src.sign, {(RW-1){1'b0}}};
            rnd_flags[1:0] = 2'b11;
        end else if (ovf_det) begin
            rnd_res      = to_inf ? {src.sign, {F_EXP{1'b1}}, {F_MANT{1'b0}}}
                                  : {src.sign, {(F_EXP-1){1'b1}}, 1'b0, {F_MANT{1'b1}}};
            rnd_flags[2] = 1'b1;
            rnd_flags[0] = 1'b1;
        end else begin
            rnd_res      = {src.sign, er[F_EXP-1:0], sum[F_MANT-1:0]};
            rnd_flags[0] = inexact;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o <= 1'b0;
            res_o   <= '0;
            flags_o <= '0;
        end else if (load) begin
            valid_o <= (state_nxt != EMPTY);
            res_o   <= rnd_res;
            flags_o <= rnd_flags;
        end
    end

`ifdef FMA_ROUND_FFLAGS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              fflags_o <= '0;
        else if (fflags_clr_i) fflags_o <= '0;
        else if (pop)          fflags_o <= fflags_o | flags_o;
    end
`else
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr_i;
    assign fflags_o          = '0;
`endif

endmodule

// File: tb/tb_lampfpu_fma_round.sv
// Bench for lampfpu_fma_round: arithmetic reference model + expected-result queue, directed vectors.
module tb_lampfpu_fma_round;
    localparam int FE = 8;
    localparam int FM = 7;
    localparam int MW = FM + 5;
    localparam int RW = 1 + FE + FM;

    typedef struct packed {
        logic          s;
        logic [FE-1:0] e;
        logic [MW-1:0] m;
        logic          ovf;
        logic          unf;
        logic          tr;
        logic          inv;
        logic [2:0]    rm;
    } in_t;

    typedef struct packed {
        logic [RW-1:0] res;
        logic [4:0]    flags;
    } out_t;

    logic clk = 1'b0;
    logic rst, valid_i, ready_i, fflags_clr;
    in_t  din;
    logic          ready_o, valid_o, drop_o;
    logic [RW-1:0] res_o;
    logic [4:0]    flags_o, fflags_o;

    int checks = 0;
    int failures = 0;
    int drops = 0;
    int hs = 0;
    out_t exp_q[$];
    logic [4:0] mff = '0;

    always #5 clk = ~clk;

    lampfpu_fma_round #(.F_EXP(FE), .F_MANT(FM)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .sign_i(din.s), .exp_i(din.e), .mant_i(din.m), .ovf_i(din.ovf), .unf_i(din.unf),
        .to_round_i(din.tr), .invalid_i(din.inv), .rnd_mode_i(din.rm),
        .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .flags_o(flags_o),
        .drop_o(drop_o), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: value in eighths of an ulp, rounded with integer arithmetic.
    function automatic out_t model(input in_t x);
        out_t o;
        int e, v, q, rem;
        bit up, inx, ovfl, ti;
        o.flags = {x.inv, 4'b0000};
        o.res   = '0;
        if (!x.tr) begin
            o.res = {x.s, x.e, x.m[MW-3:3]};
            return o;
        end
        if (x.unf) begin
            o.res   = {x.s, 15'h0000};
            o.flags = {x.inv, 4'b0011};
            return o;
        end
        e = int'(x.e);
        v = int'(x.m);
        if (v >= 2048) begin
            e = e + 1;
            v = (v / 2) | (v % 2);
        end
        q   = v / 8;
        rem = v % 8;
        inx = (rem != 0);
        case (x.rm)
            3'd1:    up = 1'b0;
            3'd2:    up = inx && x.s;
            3'd3:    up = inx && !x.s;
            3'd4:    up = (rem >= 4);
            default: up = (rem > 4) || (rem == 4 && (q % 2) == 1);
        endcase
        ovfl = x.ovf || (e >= 255) || (e == 254 && v > 255 * 8);
        q = q + int'(up);
        if (q >= 256) begin
            q = q / 2;
            e = e + 1;
        end
        ovfl = ovfl || (e >= 255);
        ti = (x.rm == 3'd1) ? 1'b0 : (x.rm == 3'd2) ? x.s : (x.rm == 3'd3) ? !x.s : 1'b1;
        if (ovfl) begin
            o.res   = ti ? {x.s, 8'hFF, 7'h00} : {x.s, 8'hFE, 7'h7F};
            o.flags = {x.inv, 4'b0101};
        end else begin
            o.res   = {x.s, e[7:0], q[6:0]};
            o.flags = {x.inv, 3'b000, inx};
        end
        return o;
    endfunction

    function automatic in_t mk(input logic s, input logic [7:0] e, input logic [11:0] m,
                               input logic ovf, input logic unf, input logic tr,
                               input logic inv, input logic [2:0] rm);
        in_t x;
        x.s = s; x.e = e; x.m = m; x.ovf = ovf; x.unf = unf; x.tr = tr; x.inv = inv; x.rm = rm;
        return x;
    endfunction

    // Every-cycle compare against the model queue, then advance the model for the next edge.
    always @(negedge clk) begin
        bit pop, dr;
        if (!rst) begin
            exp_q.delete();
            mff = '0;
            chk("rst_valid", 32'(valid_o), 32'(0));
            chk("rst_res", 32'(res_o), 32'(0));
            chk("rst_flags", 32'(flags_o), 32'(0));
            chk("rst_drop", 32'(drop_o), 32'(0));
            chk("rst_fflags", 32'(fflags_o), 32'(0));
            chk("rst_ready", 32'(ready_o), 32'(1));
        end else begin
            chk("ready", 32'(ready_o), 32'(exp_q.size() == 0));
            chk("valid", 32'(valid_o), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("res", 32'(res_o), 32'(exp_q[0].res));
                chk("flags", 32'(flags_o), 32'(exp_q[0].flags));
            end
            pop = (exp_q.size() != 0) && ready_i;
            dr  = valid_i && (exp_q.size() == 2) && !pop;
            chk("drop", 32'(drop_o), 32'(dr));
            chk("fflags", 32'(fflags_o), 32'(mff));
            if (drop_o) drops++;
`ifdef FMA_ROUND_FFLAGS_EN
            if (fflags_clr) mff = '0;
            else if (pop)   mff = mff | exp_q[0].flags;
`endif
            if (pop) begin
                hs++;
                void'(exp_q.pop_front());
            end
            if (valid_i && !dr) exp_q.push_back(model(din));
        end
    end

    task automatic run(input string name, input in_t x, input logic [15:0] r, input logic [4:0] f);
        out_t mo;
        @(posedge clk); #1;
        din = x;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, 32'(valid_o), 32'(1));
        chk({name, "_res"}, 32'(res_o), 32'(r));
        chk({name, "_flags"}, 32'(flags_o), 32'(f));
        mo = model(x);
        chk({name, "_model"}, 32'({mo.res, mo.flags}), 32'({r, f}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int d0, h0;
        rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1; fflags_clr = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        run("rne_tie",  mk(0, 8'h7F, 12'h40C, 0, 0, 1, 0, 3'd0), 16'h3F82, 5'h01);
        run("rtz",      mk(0, 8'h7F, 12'h40C, 0, 0, 1, 0, 3'd1), 16'h3F81, 5'h01);
        run("ovf_rne",  mk(0, 8'hFE, 12'h7FC, 0, 0, 1, 0, 3'd0), 16'h7F80, 5'h05);
        run("ovf_rtz",  mk(0, 8'hFE, 12'h7FC, 0, 0, 1, 0, 3'd1), 16'h7F7F, 5'h05);
        run("pass",     mk(0, 8'hFF, 12'h600, 0, 0, 0, 1, 3'd0), 16'h7FC0, 5'h10);
        run("carry_rne",mk(0, 8'h80, 12'hC05, 0, 0, 1, 0, 3'd0), 16'h40C0, 5'h01);
        run("carry_rup",mk(0, 8'h80, 12'hC05, 0, 0, 1, 0, 3'd3), 16'h40C1, 5'h01);
        run("neg_rdn",  mk(1, 8'h7F, 12'h401, 0, 0, 1, 0, 3'd2), 16'hBF81, 5'h01);
        run("neg_rup",  mk(1, 8'h7F, 12'h401, 0, 0, 1, 0, 3'd3), 16'hBF80, 5'h01);
        run("rmm_tie",  mk(0, 8'h7F, 12'h404, 0, 0, 1, 0, 3'd4), 16'h3F81, 5'h01);
        run("rne_even", mk(0, 8'h7F, 12'h404, 0, 0, 1, 0, 3'd0), 16'h3F80, 5'h01);
        run("mode5",    mk(0, 8'h7F, 12'h404, 0, 0, 1, 0, 3'd5), 16'h3F80, 5'h01);
        run("exact",    mk(0, 8'h85, 12'h418, 0, 0, 1, 0, 3'd0), 16'h4283, 5'h00);
        run("unf",      mk(1, 8'h10, 12'h400, 0, 1, 1, 0, 3'd0), 16'h8000, 5'h03);
        run("ovfi_rup", mk(1, 8'h80, 12'h400, 1, 0, 1, 0, 3'd3), 16'hFF7F, 5'h05);
        run("ovfi_rdn", mk(1, 8'h80, 12'h400, 1, 0, 1, 0, 3'd2), 16'hFF80, 5'h05);
        run("nv_round", mk(0, 8'h85, 12'h418, 0, 0, 1, 1, 3'd0), 16'h4283, 5'h10);
        run("frac_co",  mk(0, 8'h7F, 12'h7FC, 0, 0, 1, 0, 3'd0), 16'h4000, 5'h01);

        @(posedge clk); #1;
        @(negedge clk);
`ifdef FMA_ROUND_FFLAGS_EN
        chk("fflags_acc", 32'(fflags_o), 32'h17);
`else
        chk("fflags_acc", 32'(fflags_o), 32'h00);
`endif
        @(posedge clk); #1 fflags_clr = 1'b1;
        @(posedge clk); #1 fflags_clr = 1'b0;
        @(negedge clk);
        chk("fflags_clr", 32'(fflags_o), 32'h00);

        // Backpressure: three pushes into a stalled block, third is lost.
        ready_i = 1'b0;
        d0 = drops;
        @(posedge clk); #1;
        din = mk(0, 8'h7F, 12'h40C, 0, 0, 1, 0, 3'd0); valid_i = 1'b1;
        @(negedge clk);
        chk("bp_ready_first", 32'(ready_o), 32'(1));
        @(posedge clk); #1;
        din = mk(0, 8'h7F, 12'h40C, 0, 0, 1, 0, 3'd1);
        @(negedge clk);
        chk("bp_ready_low", 32'(ready_o), 32'(0));
        @(posedge clk); #1;
        din = mk(0, 8'h80, 12'hC05, 0, 0, 1, 0, 3'd0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        chk("bp_drops", 32'(drops - d0), 32'(1));
        chk("bp_head", 32'(res_o), 32'h3F82);
        @(posedge clk); #1;
        ready_i = 1'b1;
        h0 = hs;
        @(negedge clk);
        chk("bp_res1", 32'(res_o), 32'h3F82);
        @(negedge clk);
        chk("bp_res2", 32'(res_o), 32'h3F81);
        @(negedge clk);
        chk("bp_count", 32'(hs - h0), 32'(2));
        chk("bp_empty_valid", 32'(valid_o), 32'(0));
        chk("bp_empty_ready", 32'(ready_o), 32'(1));

        // Reset with two entries buffered.
        ready_i = 1'b0;
        @(posedge clk); #1;
        din = mk(0, 8'h85, 12'h418, 0, 0, 1, 0, 3'd0); valid_i = 1'b1;
        @(posedge clk); #1;
        din = mk(0, 8'h85, 12'h418, 0, 0, 1, 1, 3'd0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", 32'(valid_o), 32'(0));
        chk("rstmid_ready", 32'(ready_o), 32'(1));
        chk("rstmid_fflags", 32'(fflags_o), 32'(0));
        ready_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("rstmid_no_stale", 32'(valid_o), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
